hex_string_gen: RTL

Parametrised, streaming hex-to-ASCII converter for the text/font path. It accepts a WIDTH-bit word over a valid/ready handshake and emits its hexadecimal representation one ASCII character per beat, most significant digit first, with a last-character flag. Optional leading-zero suppression and a lowercase mode are supported. It sits between register/debug sources and the character buffer writer that feeds the font renderer.

---
 rtl/hex_string_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hex_string_gen.sv
// rtl/hex_string_gen.sv - streaming WIDTH-bit word to ASCII hex string converter
// Optional feature macro: HEX_STRING_PREFIX_EN (prepends "0x" to every string).
module hex_string_gen #(
  parameter int WIDTH = 16,
  parameter bit UPPER = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = $clog2(NDIG + 2);

  // Reject widths that do not split into whole nibbles.
  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("hex_string_gen: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt;
`ifdef HEX_STRING_PREFIX_EN
  logic [CW-1:0]    first_q;
  localparam logic [CW-1:0] IDX_ZERO_CH = CW'(NDIG + 1);
  localparam logic [CW-1:0] IDX_X_CH    = CW'(NDIG);
`endif

  // Map one nibble to its ASCII hex character.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [3:0] off;
    off = n - 4'd10;
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPER)
      return 8'h41 + {4'h0, off};
    else
      return 8'h61 + {4'h0, off};
  endfunction

  // Select nibble idx of word d (idx 0 = least significant).
  function automatic logic [3:0] nibble_at(input logic [WIDTH-1:0] d, input logic [CW-1:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < NDIG; i++)
      if (idx == CW'(i)) r = d[4*i +: 4];
    return r;
  endfunction

  // Index of the first digit to emit; an all-zero word still yields one digit.
  function automatic logic [CW-1:0] first_index(input logic [WIDTH-1:0] d, input logic lz);
    logic [CW-1:0] r;
    r = '0;
    if (!lz)
      r = CW'(NDIG - 1);
    else
      for (int i = 0; i < NDIG; i++)
        if (d[4*i +: 4] != 4'h0) r = CW'(i);
    return r;
  endfunction

  assign in_ready = (state == IDLE);

  // Control FSM; out_char/out_last are preloaded for the beat that follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
`ifdef HEX_STRING_PREFIX_EN
      first_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT;
            data_q    <= in_data;
            out_valid <= 1'b1;
`ifdef HEX_STRING_PREFIX_EN
            first_q   <= first_index(in_data, in_lz);
            cnt       <= IDX_ZERO_CH;
            out_char  <= 8'h30;
            out_last  <= 1'b0;
`else
            cnt       <= first_index(in_data, in_lz);
            out_char  <= hex_ascii(nibble_at(in_data, first_index(in_data, in_lz)));
            out_last  <= (first_index(in_data, in_lz) == '0);
`endif
          end
        end
        EMIT: begin
          if (out_ready) begin
`ifdef HEX_STRING_PREFIX_EN
            if (cnt == IDX_ZERO_CH) begin
              cnt      <= IDX_X_CH;
              out_char <= 8'h78;
              out_last <= 1'b0;
            end else if (cnt == IDX_X_CH) begin
              cnt      <= first_q;
              out_char <= hex_ascii(nibble_at(data_q, first_q));
              out_last <= (first_q == '0);
            end else
`endif
            if (cnt == '0) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              cnt      <= cnt - 1'b1;
              out_char <= hex_ascii(nibble_at(data_q, cnt - 1'b1));
              out_last <= (cnt == CW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
